// File: rtl/satalnk_pkg.sv
// Shared SATA link-layer definitions: CRC constants, the TX CRC stage
// state encoding and the dword-wide CRC step used by both TX and RX.
package satalnk_pkg;

  localparam logic [31:0] SATA_CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    CRC  = 2'd1,
    DROP = 2'd2
  } satalnk_crc_state_e;

  // One full dword folded into the CRC, MSB first, no reflection.
  function automatic logic [31:0] sata_crc32_next(input logic [31:0] crc,
                                                  input logic [31:0] dword);
    logic [31:0] c_s;
    logic        fb_s;
    c_s = crc;
    for (int i = 31; i >= 0; i--) begin
      fb_s = c_s[31] ^ dword[i];
      c_s  = {c_s[30:0], 1'b0};
      if (fb_s) begin
        c_s = c_s ^ SATA_CRC_POLY;
      end else begin
        c_s = c_s;
      end
    end
    return c_s;
  endfunction

endpackage

// File: rtl/satalnk_txcrc_if.sv
// Dword stream bundle (valid/ready/data/last) used on both sides of the
// TX CRC stage.
interface satalnk_txcrc_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic        last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/satalnk_crc32.sv
// Running SATA CRC register: seeded with INIT, advanced one dword per
// enabled cycle, re-seeded by i_clear. Shared between the TX and RX paths.
module satalnk_crc32
  import satalnk_pkg::*;
#(
  parameter logic [31:0] INIT = SATA_CRC_INIT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);

  logic [31:0] crc_r;
  logic [31:0] crc_next_s;

  // Next CRC value: re-seed has priority over a data step.
  always_comb begin
    crc_next_s = crc_r;
    if (i_clear) begin
      crc_next_s = INIT;
    end else if (i_en) begin
      crc_next_s = sata_crc32_next(crc_r, i_data);
    end else begin
      crc_next_s = crc_r;
    end
  end

  // CRC state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_r <= INIT;
    end else begin
      crc_r <= crc_next_s;
    end
  end

  assign o_crc = crc_r;

endmodule

// File: rtl/satalnk_txcrc.sv
// Link-layer TX CRC stage. Passes FIS dwords through with one cycle of
// latency, appends the SATA CRC dword (flagged by m_last) after the final
// dword, and truncates FISes longer than MAX_DWORDS, discarding the rest.
// Optional build macro SATALNK_TXCRC_ERRINJ_EN adds i_crc_errinj, which
// flips bit 0 of the CRC dword when high as the CRC dword is loaded.
module satalnk_txcrc
  import satalnk_pkg::*;
#(
  parameter int unsigned MAX_DWORDS   = 2049,
  parameter logic        OPT_LOWPOWER = 1'b0,
  parameter logic [31:0] CRC_INIT     = SATA_CRC_INIT
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  satalnk_txcrc_if.slave         s_if,
  satalnk_txcrc_if.master        m_if,
  output logic                   o_overlen
`ifdef SATALNK_TXCRC_ERRINJ_EN
  ,
  input  logic                   i_crc_errinj
`endif
);

  localparam logic [16:0] MAX_W = 17'(MAX_DWORDS);

  satalnk_crc_state_e state_r;
  satalnk_crc_state_e state_next_s;
  logic               trunc_r;
  logic               trunc_next_s;
  logic [15:0]        count_r;
  logic [16:0]        count_inc_s;

  logic               m_valid_r;
  logic [31:0]        m_data_r;
  logic               m_last_r;
  logic               overlen_r;

  logic               adv_s;
  logic               s_ready_s;
  logic               accept_s;
  logic               payload_load_s;
  logic               crc_load_s;
  logic               out_clear_s;
  logic               trunc_hit_s;
  logic [31:0]        crc_s;
  logic [31:0]        crc_word_s;

  assign adv_s       = !m_valid_r || m_if.ready;
  assign accept_s    = s_if.valid && s_ready_s;
  assign count_inc_s = {1'b0, count_r} + 17'd1;

`ifdef SATALNK_TXCRC_ERRINJ_EN
  assign crc_word_s = crc_s ^ {31'd0, i_crc_errinj};
`else
  assign crc_word_s = crc_s;
`endif

  // State and truncation flag register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= PASS;
      trunc_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      trunc_r <= trunc_next_s;
    end
  end

  // Next-state: close on s_last or on reaching the length limit.
  always_comb begin
    state_next_s = state_r;
    trunc_next_s = trunc_r;
    case (state_r)
      PASS: begin
        if (accept_s) begin
          if (s_if.last) begin
            state_next_s = CRC;
          end else if (count_inc_s == MAX_W) begin
            state_next_s = CRC;
            trunc_next_s = 1'b1;
          end else begin
            state_next_s = PASS;
          end
        end else begin
          state_next_s = PASS;
        end
      end
      CRC: begin
        if (adv_s) begin
          state_next_s = trunc_r ? DROP : PASS;
        end else begin
          state_next_s = CRC;
        end
      end
      DROP: begin
        if (accept_s && s_if.last) begin
          state_next_s = PASS;
          trunc_next_s = 1'b0;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        state_next_s = PASS;
        trunc_next_s = 1'b0;
      end
    endcase
  end

  // Per-state handshake and datapath strobes.
  always_comb begin
    s_ready_s      = 1'b0;
    payload_load_s = 1'b0;
    crc_load_s     = 1'b0;
    out_clear_s    = 1'b0;
    trunc_hit_s    = 1'b0;
    case (state_r)
      PASS: begin
        s_ready_s      = adv_s;
        payload_load_s = s_if.valid && adv_s;
        out_clear_s    = !s_if.valid && adv_s;
        trunc_hit_s    = s_if.valid && adv_s && !s_if.last && (count_inc_s == MAX_W);
      end
      CRC: begin
        crc_load_s = adv_s;
      end
      DROP: begin
        // Dropped dwords never reach the output; a pending CRC dword
        // is only retired here, never replaced.
        s_ready_s   = 1'b1;
        out_clear_s = adv_s;
      end
      default: begin
        s_ready_s = 1'b0;
      end
    endcase
  end

  // Accepted-dword counter, cleared as the CRC dword closes the FIS so a
  // truncated FIS also starts its successor from zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_r <= 16'd0;
    end else if (crc_load_s) begin
      count_r <= 16'd0;
    end else if (payload_load_s) begin
      count_r <= count_inc_s[15:0];
    end else begin
      count_r <= count_r;
    end
  end

  // Output register: payload dword, CRC dword, or retire when drained.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= 32'd0;
      m_last_r  <= 1'b0;
    end else if (crc_load_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= crc_word_s;
      m_last_r  <= 1'b1;
    end else if (payload_load_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= s_if.data;
      m_last_r  <= 1'b0;
    end else if (out_clear_s) begin
      m_valid_r <= 1'b0;
      m_data_r  <= OPT_LOWPOWER ? 32'd0 : m_data_r;
      m_last_r  <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
      m_data_r  <= m_data_r;
      m_last_r  <= m_last_r;
    end
  end

  // Truncation pulse, one cycle per over-long FIS.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overlen_r <= 1'b0;
    end else begin
      overlen_r <= trunc_hit_s;
    end
  end

  satalnk_crc32 #(
    .INIT (CRC_INIT)
  ) u_crc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (crc_load_s),
    .i_en      (payload_load_s),
    .i_data    (s_if.data),
    .o_crc     (crc_s)
  );

  assign s_if.ready = s_ready_s;
  assign m_if.valid = m_valid_r;
  assign m_if.data  = m_data_r;
  assign m_if.last  = m_last_r;
  assign o_overlen  = overlen_r;

endmodule

// File: tb/tb_satalnk_txcrc.sv
// Bench for satalnk_txcrc: two instances (default limit, and limit 4 with
// low-power output zeroing) fed identical FIS streams, each checked
// against a FIS-level reference model.
module tb_satalnk_txcrc;

  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'h52325032;
  localparam int          MAX_A = 2049;
  localparam int          MAX_B = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk;
  logic rst_n;
`ifdef SATALNK_TXCRC_ERRINJ_EN
  logic errinj;
`endif
  logic inj_exp;

  int checks;
  int errors;
  int rdy_pct;
  int vld_pct;

  beat_t in_q  [2][$];
  beat_t out_q [2][$];
  beat_t exp_q [2][$];
  int    acc_cnt   [2];
  int    stall_cnt [2];
  int    nrdy_cnt  [2];
  int    ovl_cnt   [2];
  int    exp_ovl   [2];

  logic        mv_w  [2];
  logic [31:0] md_w  [2];
  logic        ml_w  [2];
  logic        ovl_w [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    satalnk_txcrc_if s_bus ();
    satalnk_txcrc_if m_bus ();

    satalnk_txcrc #(
      .MAX_DWORDS   ((g == 0) ? MAX_A : MAX_B),
      .OPT_LOWPOWER ((g == 0) ? 1'b0 : 1'b1),
      .CRC_INIT     (32'h52325032)
    ) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .s_if      (s_bus),
      .m_if      (m_bus),
      .o_overlen (ovl_w[g])
`ifdef SATALNK_TXCRC_ERRINJ_EN
      ,
      .i_crc_errinj (errinj)
`endif
    );

    assign mv_w[g] = m_bus.valid;
    assign md_w[g] = m_bus.data;
    assign ml_w[g] = m_bus.last;

    // Driver and monitor: inputs change on negedge, handshakes sampled just before posedge.
    initial begin
      logic        fired;
      logic        stalled;
      logic [31:0] hold_d;
      logic        hold_l;
      beat_t       b;
      fired = 1'b0; stalled = 1'b0; hold_d = 32'd0; hold_l = 1'b0;
      s_bus.valid = 1'b0; s_bus.data = 32'd0; s_bus.last = 1'b0; m_bus.ready = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          s_bus.valid = 1'b0;
          fired = 1'b0;
          stalled = 1'b0;
        end else begin
          if (fired) begin
            if (in_q[g].size() > 0) void'(in_q[g].pop_front());
            s_bus.valid = 1'b0;
            fired = 1'b0;
          end
          if (!s_bus.valid && in_q[g].size() > 0 && $urandom_range(0, 99) < vld_pct) begin
            s_bus.valid = 1'b1;
            s_bus.data  = in_q[g][0].d;
            s_bus.last  = in_q[g][0].l;
          end
          m_bus.ready = ($urandom_range(0, 99) < rdy_pct);
        end
        #4;
        if (rst_n) begin
          if (stalled) begin
            checks++;
            if (m_bus.valid !== 1'b1 || m_bus.data !== hold_d || m_bus.last !== hold_l) begin
              errors++;
              $display("FAIL stall_hold dut%0d got v=%0b %h/%0b expected v=1 %h/%0b",
                       g, m_bus.valid, m_bus.data, m_bus.last, hold_d, hold_l);
            end
          end
          stalled = m_bus.valid && !m_bus.ready;
          hold_d  = m_bus.data;
          hold_l  = m_bus.last;
          if (s_bus.valid && s_bus.ready) begin
            fired = 1'b1;
            acc_cnt[g]++;
          end
          if (s_bus.valid && !s_bus.ready) stall_cnt[g]++;
          if (!s_bus.ready) nrdy_cnt[g]++;
          if (m_bus.valid && m_bus.ready) begin
            b.d = m_bus.data;
            b.l = m_bus.last;
            out_q[g].push_back(b);
          end
          if (ovl_w[g]) ovl_cnt[g]++;
        end
      end
    end
  end

  // Low-power instance: an idle output must carry all-zero data and last.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && !mv_w[1]) begin
        checks++;
        if (md_w[1] !== 32'd0 || ml_w[1] !== 1'b0) begin
          errors++;
          $display("FAIL lowpower_idle got %h/%0b expected 00000000/0", md_w[1], ml_w[1]);
        end
      end
    end
  end

  // Reference CRC: (crc ^ dword) * x^32 mod P, computed as a plain division.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  // Queue a FIS to both instances and append each instance's expected output.
  task automatic push_fis(input logic [31:0] fis[$]);
    beat_t b;
    int    lim;
    int    n;
    logic [31:0] c;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? MAX_A : MAX_B;
      n   = (fis.size() > lim) ? lim : fis.size();
      c   = SEED;
      for (int i = 0; i < n; i++) begin
        b.d = fis[i]; b.l = 1'b0;
        exp_q[k].push_back(b);
        c = ref_crc(c, fis[i]);
      end
      b.d = c ^ {31'd0, inj_exp}; b.l = 1'b1;
      exp_q[k].push_back(b);
      if (fis.size() > lim) exp_ovl[k]++;
      for (int i = 0; i < fis.size(); i++) begin
        b.d = fis[i]; b.l = (i == fis.size() - 1);
        in_q[k].push_back(b);
      end
    end
  endtask

  task automatic clear_bufs();
    for (int k = 0; k < 2; k++) begin
      in_q[k].delete(); out_q[k].delete(); exp_q[k].delete();
      acc_cnt[k] = 0; stall_cnt[k] = 0; nrdy_cnt[k] = 0; ovl_cnt[k] = 0; exp_ovl[k] = 0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (cyc < budget && !(in_q[0].size() == 0 && in_q[1].size() == 0 &&
           out_q[0].size() >= exp_q[0].size() && out_q[1].size() >= exp_q[1].size() &&
           !mv_w[0] && !mv_w[1])) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d/%0d beats expected %0d/%0d", name,
               out_q[0].size(), out_q[1].size(), exp_q[0].size(), exp_q[1].size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mv_w[k] !== 1'b0 || md_w[k] !== 32'd0 || ml_w[k] !== 1'b0 || ovl_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got v=%0b d=%h l=%0b o=%0b expected all 0",
                 k, mv_w[k], md_w[k], ml_w[k], ovl_w[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] fis[$];
    clear_bufs(); rdy_pct = 100; vld_pct = 100;
    fis.push_back(32'h00000027);
    push_fis(fis);
    wait_drain("single", 200);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL single_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL single_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
      checks++;
      if (nrdy_cnt[k] !== 1) begin
        errors++;
        $display("FAIL single_bubble dut%0d got %0d s_ready-low cycles expected 1", k, nrdy_cnt[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fis[$];
    clear_bufs(); rdy_pct = 100; vld_pct = 100;
    fis = '{32'h00000046, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
    push_fis(fis);
    fis = '{32'h00000034};
    push_fis(fis);
    wait_drain("b2b", 300);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL b2b_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL b2b_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
    end
    checks++;
    if (out_q[0].size() !== 8) begin
      errors++;
      $display("FAIL b2b_count got %0d beats expected 8", out_q[0].size());
    end
    checks++;
    if (stall_cnt[0] !== 1) begin
      errors++;
      $display("FAIL b2b_bubble got %0d stall cycles expected 1", stall_cnt[0]);
    end
  endtask

  task automatic test_overlen();
    logic [31:0] fis[$];
    clear_bufs(); rdy_pct = 100; vld_pct = 100;
    for (int i = 0; i < 7; i++) fis.push_back($urandom);
    push_fis(fis);
    fis.delete();
    for (int i = 0; i < 3; i++) fis.push_back($urandom);
    push_fis(fis);
    wait_drain("overlen", 300);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL overlen_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL overlen_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
      checks++;
      if (ovl_cnt[k] !== exp_ovl[k]) begin
        errors++;
        $display("FAIL overlen_pulse dut%0d got %0d pulses expected %0d", k, ovl_cnt[k], exp_ovl[k]);
      end
      checks++;
      if (acc_cnt[k] !== 10) begin
        errors++;
        $display("FAIL overlen_consumed dut%0d got %0d accepted expected 10", k, acc_cnt[k]);
      end
    end
  endtask

  task automatic test_exact_limit();
    logic [31:0] fis[$];
    clear_bufs(); rdy_pct = 100; vld_pct = 100;
    for (int i = 0; i < MAX_B; i++) fis.push_back($urandom);
    push_fis(fis);
    wait_drain("exact", 200);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL exact_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL exact_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
      checks++;
      if (ovl_cnt[k] !== 0) begin
        errors++;
        $display("FAIL exact_overlen dut%0d got %0d pulses expected 0", k, ovl_cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] fis[$];
    int len;
    clear_bufs(); rdy_pct = 50; vld_pct = 80;
    for (int f = 0; f < 200; f++) begin
      fis.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) fis.push_back($urandom);
      push_fis(fis);
    end
    wait_drain("random", 40000);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL random_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL random_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
      checks++;
      if (ovl_cnt[k] !== exp_ovl[k]) begin
        errors++;
        $display("FAIL random_overlen dut%0d got %0d pulses expected %0d", k, ovl_cnt[k], exp_ovl[k]);
      end
    end
    rdy_pct = 100; vld_pct = 100;
  endtask

  task automatic test_reset_midfis();
    logic [31:0] fis[$];
    beat_t b;
    int guard;
    clear_bufs(); rdy_pct = 100; vld_pct = 100;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        b.d = $urandom; b.l = (i == 4);
        in_q[k].push_back(b);
      end
    end
    guard = 0;
    while (acc_cnt[0] < 2 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++;
    if (acc_cnt[0] < 2) begin
      errors++;
      $display("FAIL midreset_wait got %0d accepted expected 2", acc_cnt[0]);
    end
    checks++;
    if (mv_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got m_valid=%0b expected 1", mv_w[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mv_w[k] !== 1'b0 || md_w[k] !== 32'd0 || ml_w[k] !== 1'b0 || ovl_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_async dut%0d got v=%0b d=%h l=%0b o=%0b expected all 0",
                 k, mv_w[k], md_w[k], ml_w[k], ovl_w[k]);
      end
    end
    clear_bufs();
    repeat (2) @(negedge clk);
    clear_bufs();
    rst_n = 1'b1;
    fis.push_back($urandom);
    fis.push_back($urandom);
    push_fis(fis);
    wait_drain("midreset", 200);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL midreset_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL midreset_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
    end
  endtask

`ifdef SATALNK_TXCRC_ERRINJ_EN
  task automatic test_errinj();
    logic [31:0] fis[$];
    clear_bufs(); rdy_pct = 100; vld_pct = 100;
    errinj = 1'b1; inj_exp = 1'b1;
    fis = '{32'h00000027, 32'h12345678};
    push_fis(fis);
    wait_drain("errinj", 200);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL errinj_len dut%0d got %0d beats expected %0d", k, out_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < out_q[k].size() && i < exp_q[k].size(); i++) begin
        checks++;
        if (out_q[k][i] !== exp_q[k][i]) begin
          errors++;
          $display("FAIL errinj_beat dut%0d[%0d] got %h/%0b expected %h/%0b", k, i,
                   out_q[k][i].d, out_q[k][i].l, exp_q[k][i].d, exp_q[k][i].l);
        end
      end
    end
    errinj = 1'b0; inj_exp = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rdy_pct = 100; vld_pct = 100;
    inj_exp = 1'b0;
`ifdef SATALNK_TXCRC_ERRINJ_EN
    errinj = 1'b0;
`endif
    rst_n = 1'b0;
    clear_bufs();
    test_reset();
    test_single();
    test_back_to_back();
    test_overlen();
    test_exact_limit();
    test_random();
    test_reset_midfis();
`ifdef SATALNK_TXCRC_ERRINJ_EN
    test_errinj();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
